// File: rtl/count_min_sec.sv
// BCD seconds/minutes stage of the digital clock: counts 1 s carries, supports key-driven set mode,
// and raises the combinational 1 h carry for the hour stage.
module count_min_sec #(
    parameter logic [7:0] SEC_LIMIT = 8'h59,
    parameter logic [7:0] MIN_LIMIT = 8'h59
) (
    input  logic       clk_100Hz,
    input  logic       rst,
    input  logic       en,
    input  logic       carry_in,
    input  logic       set_mode,
    input  logic       key_sec,
    input  logic       key_min,
    input  logic       clr,
    output logic [7:0] cnt_sec,
    output logic [7:0] cnt_min,
    output logic       carry_1h
);

    logic [7:0] cnt_sec_q;
    logic [7:0] cnt_sec_d;
    logic [7:0] cnt_min_q;
    logic [7:0] cnt_min_d;
    logic       key_sec_q;
    logic       key_sec_d;
    logic       key_min_q;
    logic       key_min_d;
    logic       tick_s;
    logic       sec_edge_s;
    logic       min_edge_s;
    logic       sec_at_lim_s;
    logic       min_at_lim_s;

    // Out-of-range values and illegal units digits collapse toward a legal count.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v >= lim) begin
            r = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Next-state selection: clear, then set-mode keys, then run-mode tick, else hold.
    always_comb begin
        tick_s       = en & carry_in & ~set_mode & ~clr;
        sec_edge_s   = key_sec & ~key_sec_q;
        min_edge_s   = key_min & ~key_min_q;
        sec_at_lim_s = (cnt_sec_q == SEC_LIMIT);
        min_at_lim_s = (cnt_min_q == MIN_LIMIT);
        key_sec_d    = key_sec;
        key_min_d    = key_min;
        cnt_sec_d    = cnt_sec_q;
        cnt_min_d    = cnt_min_q;
        if (clr) begin
            cnt_sec_d = 8'h00;
            cnt_min_d = 8'h00;
        end else if (set_mode) begin
            if (sec_edge_s) begin
                cnt_sec_d = bcd_step(cnt_sec_q, SEC_LIMIT);
            end else begin
                cnt_sec_d = cnt_sec_q;
            end
            if (min_edge_s) begin
                cnt_min_d = bcd_step(cnt_min_q, MIN_LIMIT);
            end else begin
                cnt_min_d = cnt_min_q;
            end
        end else if (tick_s) begin
            cnt_sec_d = bcd_step(cnt_sec_q, SEC_LIMIT);
            if (sec_at_lim_s) begin
                cnt_min_d = bcd_step(cnt_min_q, MIN_LIMIT);
            end else begin
                cnt_min_d = cnt_min_q;
            end
        end else begin
            cnt_sec_d = cnt_sec_q;
            cnt_min_d = cnt_min_q;
        end
    end

    // Hour carry is combinational so the hour stage advances on the same edge as the 00:00 wrap.
    always_comb begin
        carry_1h = tick_s & sec_at_lim_s & min_at_lim_s & ~rst;
    end

    // Count and key-history registers; key history runs in every mode so held keys never re-step.
    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            cnt_sec_q <= 8'h00;
            cnt_min_q <= 8'h00;
            key_sec_q <= 1'b0;
            key_min_q <= 1'b0;
        end else begin
            cnt_sec_q <= cnt_sec_d;
            cnt_min_q <= cnt_min_d;
            key_sec_q <= key_sec_d;
            key_min_q <= key_min_d;
        end
    end

    assign cnt_sec = cnt_sec_q;
    assign cnt_min = cnt_min_q;

endmodule

// File: tb/tb_count_min_sec.sv
// Self-checking bench for count_min_sec: directed steps plus random stimulus against an
// integer seconds/minutes reference model.
module tb_count_min_sec;

    logic       clk_100Hz = 1'b0;
    logic       rst       = 1'b0;
    logic       en        = 1'b0;
    logic       carry_in  = 1'b0;
    logic       set_mode  = 1'b0;
    logic       key_sec   = 1'b0;
    logic       key_min   = 1'b0;
    logic       clr       = 1'b0;
    logic [7:0] cnt_sec;
    logic [7:0] cnt_min;
    logic       carry_1h;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_sec    = 0;
    int   m_min    = 0;
    logic m_pks    = 1'b0;
    logic m_pkm    = 1'b0;

    always #5 clk_100Hz = ~clk_100Hz;

    count_min_sec dut (
        .clk_100Hz (clk_100Hz),
        .rst       (rst),
        .en        (en),
        .carry_in  (carry_in),
        .set_mode  (set_mode),
        .key_sec   (key_sec),
        .key_min   (key_min),
        .clr       (clr),
        .cnt_sec   (cnt_sec),
        .cnt_min   (cnt_min),
        .carry_1h  (carry_1h)
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check the carry before the edge, advance the model, check counts.
    task automatic cyc(input logic i_en, input logic i_ci, input logic i_sm,
                       input logic i_ks, input logic i_km, input logic i_clr, input string tag);
        logic exp_c;
        logic es;
        logic em;
        int   t;
        @(negedge clk_100Hz);
        en       = i_en;
        carry_in = i_ci;
        set_mode = i_sm;
        key_sec  = i_ks;
        key_min  = i_km;
        clr      = i_clr;
        #1;
        exp_c = i_en & i_ci & ~i_sm & ~i_clr & (m_sec == 59) & (m_min == 59);
        check1({tag, "/carry_1h"}, carry_1h, exp_c);
        @(posedge clk_100Hz);
        es = i_ks & ~m_pks;
        em = i_km & ~m_pkm;
        if (i_clr) begin
            m_sec = 0;
            m_min = 0;
        end else if (i_sm) begin
            if (es) m_sec = (m_sec + 1) % 60;
            if (em) m_min = (m_min + 1) % 60;
        end else if (i_en && i_ci) begin
            t     = (m_min * 60 + m_sec + 1) % 3600;
            m_min = t / 60;
            m_sec = t % 60;
        end
        m_pks = i_ks;
        m_pkm = i_km;
        #1;
        check8({tag, "/cnt_sec"}, cnt_sec, to_bcd(m_sec));
        check8({tag, "/cnt_min"}, cnt_min, to_bcd(m_min));
    endtask

    // Clear in set mode, then step to the requested time with single key presses.
    task automatic set_time(input int s, input int mn);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "set_clr");
        for (int i = 0; i < s; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "set_sec_hi");
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "set_sec_lo");
        end
        for (int i = 0; i < mn; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "set_min_hi");
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "set_min_lo");
        end
    endtask

    initial begin
        // Power-on reset
        #1;
        rst = 1'b1;
        #1;
        check8("reset/cnt_sec", cnt_sec, 8'h00);
        check8("reset/cnt_min", cnt_min, 8'h00);
        check1("reset/carry_1h", carry_1h, 1'b0);
        @(negedge clk_100Hz);
        @(negedge clk_100Hz);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_idle");

        // Run counting: a pulse every 100 clocks
        for (int p = 1; p <= 61; p++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "run_pulse");
            if (p == 10) check8("pulse10_sec", cnt_sec, 8'h10);
            if (p == 60) begin
                check8("pulse60_sec", cnt_sec, 8'h00);
                check8("pulse60_min", cnt_min, 8'h01);
            end
            if (p == 61) check8("pulse61_sec", cnt_sec, 8'h01);
            for (int k = 0; k < 99; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "run_gap");
        end

        // Clear with key edges in set mode
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "clr_keys");
        check8("clr_keys_sec", cnt_sec, 8'h00);
        check8("clr_keys_min", cnt_min, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "clr_keys_rel");

        // Async reset from 12:34 between clock edges
        set_time(34, 12);
        check8("set_1234_sec", cnt_sec, 8'h34);
        check8("set_1234_min", cnt_min, 8'h12);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "exit_set");
        @(negedge clk_100Hz);
        #2;
        rst = 1'b1;
        #1;
        check8("async_rst_sec", cnt_sec, 8'h00);
        check8("async_rst_min", cnt_min, 8'h00);
        check1("async_rst_carry", carry_1h, 1'b0);
        m_sec = 0;
        m_min = 0;
        m_pks = 1'b0;
        m_pkm = 1'b0;
        @(negedge clk_100Hz);
        @(negedge clk_100Hz);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_release_idle");

        // Both keys in the same cycle
        set_time(34, 12);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "both_keys");
        check8("both_keys_sec", cnt_sec, 8'h35);
        check8("both_keys_min", cnt_min, 8'h13);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "both_keys_rel");

        // Hour rollover
        set_time(59, 59);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "exit_set");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rollover");
        check8("rollover_sec", cnt_sec, 8'h00);
        check8("rollover_min", cnt_min, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_rollover");

        // Gating by en and by set mode at 59:59
        set_time(59, 59);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gate_en");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gate_set");
        check8("gate_sec", cnt_sec, 8'h59);
        check8("gate_min", cnt_min, 8'h59);

        // Seconds key from 59 wraps without minute carry; then a long hold steps once
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "sec_wrap_key");
        check8("sec_wrap_sec", cnt_sec, 8'h00);
        check8("sec_wrap_min", cnt_min, 8'h59);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "sec_wrap_rel");
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "hold50");
        check8("hold50_sec", cnt_sec, 8'h01);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hold50_rel");

        // Key held before entering set mode gives no step
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "prehold_run");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "prehold_set");
        check8("prehold_sec", cnt_sec, 8'h01);
        check8("prehold_min", cnt_min, 8'h59);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "prehold_rel");

        // Clear beats a rollover tick
        set_time(59, 59);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "exit_set");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "clr_vs_tick");
        check8("clr_vs_tick_sec", cnt_sec, 8'h00);
        check8("clr_vs_tick_min", cnt_min, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 10) != 0, ($urandom % 3) == 0, ($urandom % 6) == 0,
                ($urandom % 2) == 1, ($urandom % 2) == 1, ($urandom % 80) == 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
